// File: rtl/game_pkg.sv
// Shared types and widths for the game-round scoring blocks.
// Imported by the debouncer and the hit_counter top.
package game_pkg;

    localparam int HIT_CNT_W = 8;
    localparam int TIMER_W   = 32;

    localparam logic [HIT_CNT_W-1:0] MAX_COUNT_DEF = 8'd99;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } round_state_t;

    // Never returns a value above max, even if cnt somehow exceeds it.
    function automatic logic [HIT_CNT_W-1:0] sat_inc(
        input logic [HIT_CNT_W-1:0] cnt,
        input logic [HIT_CNT_W-1:0] max
    );
        return (cnt >= max) ? max : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchroniser, stability-count debouncer and rising-edge pulse
// for one raw asynchronous button or sensor level.
module debouncer
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic hit_pulse
);

    localparam int CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db_level;
    logic             r_db_prev;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
            r_pulse    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1   <= i_level;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_level;
            r_pulse   <= r_db_level & ~r_db_prev;
            if (r_sync2 != r_db_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_db_level <= r_sync2;
                    r_cnt      <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign hit_pulse = r_pulse;

endmodule

// File: rtl/hit_counter.sv
// Round FSM, round timer and saturating hit score for one timed game round.
// Feeds hit_count to the sevenseg display stage.
module hit_counter
    import game_pkg::*;
#(
    parameter int                     DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [TIMER_W-1:0]     ROUND_CYCLES    = 32'd3_000_000_000,
    parameter logic [HIT_CNT_W-1:0]   MAX_COUNT       = MAX_COUNT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hit_in,
    input  logic                 start,
    input  logic                 clear,
    output logic [HIT_CNT_W-1:0] hit_count,
    output logic                 round_active,
    output logic                 round_done
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = ROUND_CYCLES - 1'b1;

    logic                 w_hit_pulse;

    round_state_t         r_state;
    logic [TIMER_W-1:0]   r_timer;
    logic [HIT_CNT_W-1:0] r_count;
    logic                 r_active;
    logic                 r_done;

    round_state_t         w_state_nxt;
    logic [TIMER_W-1:0]   w_timer_nxt;
    logic [HIT_CNT_W-1:0] w_count_nxt;
    logic                 w_active_nxt;
    logic                 w_done_nxt;

    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_hit_db (
        .clk       (clk),
        .rst       (rst),
        .i_level   (hit_in),
        .hit_pulse (w_hit_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_count  <= w_count_nxt;
            r_active <= w_active_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Priority: clear > start > expiry > hit; expiry and a hit may coincide.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_count_nxt  = r_count;
        w_active_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
            w_count_nxt = '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_state_nxt  = ST_ACTIVE;
                        w_timer_nxt  = '0;
                        w_count_nxt  = '0;
                        w_active_nxt = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    w_active_nxt = 1'b1;
                    w_timer_nxt  = r_timer + 1'b1;
                    if (w_hit_pulse) begin
                        w_count_nxt = sat_inc(r_count, MAX_COUNT);
                    end
                    if (r_timer == TIMER_LAST) begin
                        w_state_nxt  = ST_DONE;
                        w_timer_nxt  = r_timer;
                        w_active_nxt = 1'b0;
                        w_done_nxt   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    assign hit_count    = r_count;
    assign round_active = r_active;
    assign round_done   = r_done;

endmodule

// File: tb/tb_hit_counter.sv
// Directed bench for hit_counter: dut_a runs 200-cycle rounds,
// dut_b runs 5000-cycle rounds for the saturation scenario.
module tb_hit_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       hit_in;
    logic       start;
    logic       clear;
    logic [7:0] count_a;
    logic       active_a;
    logic       done_a;
    logic [7:0] count_b;
    logic       active_b;
    logic       done_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt_a = 0;
    int done_cyc_a = 0;
    int done_cnt_b = 0;

    always #5 clk = ~clk;

    hit_counter #(
        .DEBOUNCE_CYCLES (4),
        .ROUND_CYCLES    (32'd200),
        .MAX_COUNT       (8'd99)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .hit_in       (hit_in),
        .start        (start),
        .clear        (clear),
        .hit_count    (count_a),
        .round_active (active_a),
        .round_done   (done_a)
    );

    hit_counter #(
        .DEBOUNCE_CYCLES (4),
        .ROUND_CYCLES    (32'd5000),
        .MAX_COUNT       (8'd99)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .hit_in       (hit_in),
        .start        (start),
        .clear        (clear),
        .hit_count    (count_b),
        .round_active (active_b),
        .round_done   (done_b)
    );

    // Reads the pre-edge outputs; done_cyc_a is the edge index done rose on.
    always @(posedge clk) begin
        if (done_a === 1'b1) begin
            done_cnt_a++;
            done_cyc_a = cyc;
        end
        if (done_b === 1'b1) done_cnt_b++;
        cyc <= cyc + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clean_hit(input int hi, input int lo);
        hit_in = 1'b1;
        repeat (hi) tick;
        hit_in = 1'b0;
        repeat (lo) tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        hit_in = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        repeat (3) tick;
        checks++;
        if (count_a !== 8'd0 || active_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got cnt=%0d act=%b done=%b want 0/0/0",
                     count_a, active_a, done_a);
        end
        rst = 1'b0;
        repeat (5) clean_hit(8, 8);
        repeat (10) tick;
        checks++;
        if (count_a !== 8'd0 || active_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_hits: got cnt=%0d act=%b want 0/0",
                     count_a, active_a);
        end
        checks++;
        if (done_cnt_a !== 0 || done_cnt_b !== 0) begin
            errors++;
            $display("FAIL idle_no_done: got %0d/%0d pulses want 0/0",
                     done_cnt_a, done_cnt_b);
        end
    endtask

    task automatic test_basic_count;
        int s_cyc;
        int snap;
        snap = done_cnt_a;
        start = 1'b1;
        tick;
        start = 1'b0;
        s_cyc = cyc;
        checks++;
        if (active_a !== 1'b1 || count_a !== 8'd0) begin
            errors++;
            $display("FAIL start_active: got act=%b cnt=%0d want 1/0",
                     active_a, count_a);
        end
        for (int i = 0; i < 10; i++) begin
            hit_in = 1'b1;
            repeat (7) tick;
            checks++;
            if (count_a !== 8'(i)) begin
                errors++;
                $display("FAIL hit_early[%0d]: got %0d want %0d",
                         i, count_a, i);
            end
            tick;
            checks++;
            if (count_a !== 8'(i + 1)) begin
                errors++;
                $display("FAIL hit_latency[%0d]: got %0d want %0d",
                         i, count_a, i + 1);
            end
            hit_in = 1'b0;
            repeat (8) tick;
        end
        checks++;
        if (done_cnt_a !== snap) begin
            errors++;
            $display("FAIL early_done: got %0d pulses want %0d",
                     done_cnt_a, snap);
        end
        for (int k = 0; k < 100 && done_cnt_a == snap; k++) tick;
        checks++;
        if (done_cnt_a !== snap + 1) begin
            errors++;
            $display("FAIL done_pulse: got %0d pulses want %0d",
                     done_cnt_a, snap + 1);
        end
        checks++;
        if (done_cyc_a - s_cyc !== 200) begin
            errors++;
            $display("FAIL round_len: got %0d cycles want 200",
                     done_cyc_a - s_cyc);
        end
        checks++;
        if (active_a !== 1'b0 || count_a !== 8'd10) begin
            errors++;
            $display("FAIL done_hold: got act=%b cnt=%0d want 0/10",
                     active_a, count_a);
        end
        clean_hit(8, 8);
        checks++;
        if (count_a !== 8'd10 || done_cnt_a !== snap + 1) begin
            errors++;
            $display("FAIL done_discard: got cnt=%0d pulses=%0d want 10/%0d",
                     count_a, done_cnt_a, snap + 1);
        end
    endtask

    task automatic test_bounce;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (count_a !== 8'd0 || active_a !== 1'b1) begin
            errors++;
            $display("FAIL restart: got cnt=%0d act=%b want 0/1",
                     count_a, active_a);
        end
        repeat (10) clean_hit(3, 3);
        repeat (10) tick;
        checks++;
        if (count_a !== 8'd0) begin
            errors++;
            $display("FAIL glitch_reject: got %0d want 0", count_a);
        end
        clean_hit(10, 10);
        checks++;
        if (count_a !== 8'd1) begin
            errors++;
            $display("FAIL long_pulse: got %0d want 1", count_a);
        end
    endtask

    task automatic test_saturation;
        int exp_cnt;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i <= 105; i++) begin
            clean_hit(8, 8);
            exp_cnt = (i > 99) ? 99 : i;
            checks++;
            if (count_b !== 8'(exp_cnt)) begin
                errors++;
                $display("FAIL saturate[%0d]: got %0d want %0d",
                         i, count_b, exp_cnt);
            end
        end
        checks++;
        if (active_b !== 1'b1) begin
            errors++;
            $display("FAIL sat_active: got %b want 1", active_b);
        end
    endtask

    task automatic test_clear;
        int s_cyc;
        int snap;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (6) clean_hit(8, 8);
        checks++;
        if (count_a !== 8'd6 || active_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_clear: got cnt=%0d act=%b want 6/1",
                     count_a, active_a);
        end
        snap = done_cnt_a;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        checks++;
        if (count_a !== 8'd0 || active_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL clear_now: got cnt=%0d act=%b done=%b want 0/0/0",
                     count_a, active_a, done_a);
        end
        checks++;
        if (count_b !== 8'd0 || active_b !== 1'b0) begin
            errors++;
            $display("FAIL clear_b: got cnt=%0d act=%b want 0/0",
                     count_b, active_b);
        end
        repeat (250) tick;
        checks++;
        if (done_cnt_a !== snap || active_a !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle: got pulses=%0d act=%b want %0d/0",
                     done_cnt_a, active_a, snap);
        end
        start = 1'b1;
        tick;
        start = 1'b0;
        s_cyc = cyc;
        for (int k = 0; k < 250 && done_cnt_a == snap; k++) tick;
        checks++;
        if (done_cnt_a !== snap + 1 || done_cyc_a - s_cyc !== 200) begin
            errors++;
            $display("FAIL fresh_round: got pulses=%0d len=%0d want %0d/200",
                     done_cnt_a, done_cyc_a - s_cyc, snap + 1);
        end
    endtask

    task automatic test_simultaneous;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (192) tick;
        hit_in = 1'b1;
        repeat (8) tick;
        checks++;
        if (done_a !== 1'b1 || count_a !== 8'd1 || active_a !== 1'b0) begin
            errors++;
            $display("FAIL expiry_hit: got done=%b cnt=%0d act=%b want 1/1/0",
                     done_a, count_a, active_a);
        end
        hit_in = 1'b0;
        repeat (10) tick;
        checks++;
        if (count_a !== 8'd1) begin
            errors++;
            $display("FAIL expiry_hold: got %0d want 1", count_a);
        end
        hit_in = 1'b1;
        repeat (7) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (count_a !== 8'd0 || active_a !== 1'b1) begin
            errors++;
            $display("FAIL start_hit: got cnt=%0d act=%b want 0/1",
                     count_a, active_a);
        end
        hit_in = 1'b0;
        repeat (10) tick;
        checks++;
        if (count_a !== 8'd0 || active_a !== 1'b1) begin
            errors++;
            $display("FAIL start_hit_drop: got cnt=%0d act=%b want 0/1",
                     count_a, active_a);
        end
    endtask

    initial begin
        test_reset;
        test_basic_count;
        test_bounce;
        test_saturation;
        test_clear;
        test_simultaneous;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
